// File: rtl/sseg_frame_decoder.sv
// Receive-side decoder for a 3-digit multiplexed, active-low seven-segment bus.
// It synchronises the bus and waits for each digit to hold steady before latching it.
// Each latched pattern is decoded back to BCD.
// Complete frames are published as 12-bit BCD plus 10-bit binary (0..999).
// Error flags report bad patterns, misplaced decimal points and overlapping enables.
// A stale flag reports a bus that has stopped producing frames.
//
// Handshake: frame_valid is a single-cycle strobe with no back-pressure.
// bcd_out, value_out and changed are valid in the cycle frame_valid is high.
// bcd_out and value_out then hold until the next frame.
module sseg_frame_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 16,
    parameter int TIMEOUT     = 48000,
    parameter int DP_DIGIT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  en_in,
    input  logic [7:0]  sseg_in,
    output logic [11:0] bcd_out,
    output logic [9:0]  value_out,
    output logic        frame_valid,
    output logic        changed,
    output logic        seg_err,
    output logic        dp_err,
    output logic        en_err,
    output logic        stale,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);
    localparam logic [1:0]    DPD       = 2'(DP_DIGIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        snap_en;
    logic [7:0]        snap_seg;
    logic [2:0][3:0]   slot;
    logic [2:0]        mask;
    logic              frame_pend;
    logic              have_frame;
    logic [TW-1:0]     tcnt;

    logic [2:0]        en_s;
    logic [7:0]        sseg_s;

    // Input synchroniser; idle bus (all ones) is the reset value
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign en_s   = en_in;
            assign sseg_s = sseg_in;
        end else begin : g_sync
            logic [2:0] en_pipe  [SYNC_STAGES];
            logic [7:0] seg_pipe [SYNC_STAGES];
            // Shift raw bus through SYNC_STAGES flops
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        en_pipe[i]  <= '1;
                        seg_pipe[i] <= '1;
                    end
                end else begin
                    en_pipe[0]  <= en_in;
                    seg_pipe[0] <= sseg_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        en_pipe[i]  <= en_pipe[i-1];
                        seg_pipe[i] <= seg_pipe[i-1];
                    end
                end
            end
            assign en_s   = en_pipe[SYNC_STAGES-1];
            assign sseg_s = seg_pipe[SYNC_STAGES-1];
        end
    endgenerate

    // Exact-match segment decode: {valid, bcd}; input is sseg[7:1] = a..g
    function automatic logic [4:0] dec7(input logic [6:0] p);
        case (p)
            7'h01:   dec7 = {1'b1, 4'd0};
            7'h4F:   dec7 = {1'b1, 4'd1};
            7'h12:   dec7 = {1'b1, 4'd2};
            7'h06:   dec7 = {1'b1, 4'd3};
            7'h4C:   dec7 = {1'b1, 4'd4};
            7'h24:   dec7 = {1'b1, 4'd5};
            7'h20:   dec7 = {1'b1, 4'd6};
            7'h0F:   dec7 = {1'b1, 4'd7};
            7'h00:   dec7 = {1'b1, 4'd8};
            7'h04:   dec7 = {1'b1, 4'd9};
            default: dec7 = 5'd0;
        endcase
    endfunction

    // Digit index of a one-hot-low enable
    function automatic logic [1:0] en_idx(input logic [2:0] e);
        case (e)
            3'b110:  en_idx = 2'd0;
            3'b101:  en_idx = 2'd1;
            3'b011:  en_idx = 2'd2;
            default: en_idx = 2'd0;
        endcase
    endfunction

    logic        one_low;
    logic        multi_low;
    logic        same;
    logic        latch_fire;
    logic [4:0]  dec;
    logic [1:0]  latch_digit;
    logic [2:0]  latch_bit;
    logic [2:0]  mask_base;
    logic [2:0]  mask_next;
    logic [11:0] frame_bcd;
    logic [9:0]  frame_val;
    logic [9:0]  h10, t10, o10;

    // Classification of the current sample and latch/frame bookkeeping
    always_comb begin
        one_low     = (en_s == 3'b110) || (en_s == 3'b101) || (en_s == 3'b011);
        multi_low   = !one_low && (en_s != 3'b111);
        same        = (en_s == snap_en) && (sseg_s == snap_seg);
        latch_fire  = (state == ST_SETTLE) && same && (cnt == SETTLE_M1);
        dec         = dec7(snap_seg[7:1]);
        latch_digit = en_idx(snap_en);
        latch_bit   = 3'b001 << latch_digit;
        // A frame publishing this cycle clears the mask under any new latch
        mask_base   = frame_pend ? 3'b000 : mask;
        mask_next   = mask_base | ((latch_fire && dec[4]) ? latch_bit : 3'b000);
        frame_bcd   = {slot[2], slot[1], slot[0]};
        h10         = {6'd0, slot[2]};
        t10         = {6'd0, slot[1]};
        o10         = {6'd0, slot[0]};
        frame_val   = (h10 << 6) + (h10 << 5) + (h10 << 2)
                    + (t10 << 3) + (t10 << 1) + o10;
    end

    // Digit FSM, slot/mask capture, error flags and frame publication
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            snap_en     <= 3'b111;
            snap_seg    <= 8'hFF;
            slot        <= '0;
            mask        <= 3'b000;
            frame_pend  <= 1'b0;
            have_frame  <= 1'b0;
            bcd_out     <= '0;
            value_out   <= '0;
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            seg_err     <= 1'b0;
            dp_err      <= 1'b0;
            en_err      <= 1'b0;
        end else begin
            en_err      <= multi_low;
            frame_valid <= 1'b0;
            changed     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (one_low) begin
                        state    <= ST_SETTLE;
                        cnt      <= CNT_ONE;
                        snap_en  <= en_s;
                        snap_seg <= sseg_s;
                    end
                end
                ST_SETTLE: begin
                    if (same) begin
                        if (cnt == SETTLE_M1) begin
                            state <= ST_HOLD;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else if (one_low) begin
                        cnt      <= CNT_ONE;
                        snap_en  <= en_s;
                        snap_seg <= sseg_s;
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                ST_HOLD: begin
                    // Only an enable change ends the hold window
                    if (en_s != snap_en) begin
                        if (one_low) begin
                            state    <= ST_SETTLE;
                            cnt      <= CNT_ONE;
                            snap_en  <= en_s;
                            snap_seg <= sseg_s;
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase

            if (latch_fire) begin
                if (dec[4]) begin
                    slot[latch_digit] <= dec[3:0];
                    // dp lit (low) must coincide exactly with the dp digit
                    if ((!snap_seg[0]) != (latch_digit == DPD)) begin
                        dp_err <= 1'b1;
                    end
                end else begin
                    seg_err <= 1'b1;
                end
            end

            mask       <= mask_next;
            frame_pend <= latch_fire && dec[4] && (mask_next == 3'b111);

            if (frame_pend) begin
                bcd_out     <= frame_bcd;
                value_out   <= frame_val;
                frame_valid <= 1'b1;
                changed     <= !have_frame || (frame_bcd != bcd_out);
                have_frame  <= 1'b1;
            end
        end
    end

    // Frame timeout counter, restarted whenever a frame is published
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (frame_pend) begin
            tcnt <= '0;
        end else if (tcnt != TMAX) begin
            tcnt <= tcnt + TW'(1);
        end
    end

    assign stale     = (tcnt == TMAX);
    assign dbg_state = state;

endmodule

// File: tb/tb_sseg_frame_decoder.sv
// Self-checking bench for sseg_frame_decoder: directed bus scans.
// Expected frames are queued and matched by a separate monitor.
module tb_sseg_frame_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int SETTLE      = 16;
    localparam int TIMEOUT     = 300;
    localparam int DP_DIGIT    = 1;
    localparam int HOLD_CYC    = 32;
    localparam int W           = 23;   // {bcd[11:0], value[9:0], changed}

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  en_in = 3'b111;
    logic [7:0]  sseg_in = 8'hFF;
    logic [11:0] bcd_out;
    logic [9:0]  value_out;
    logic        frame_valid, changed, seg_err, dp_err, en_err, stale;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    sseg_frame_decoder #(
        .SYNC_STAGES(SYNC_STAGES),
        .SETTLE     (SETTLE),
        .TIMEOUT    (TIMEOUT),
        .DP_DIGIT   (DP_DIGIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_in      (en_in),
        .sseg_in    (sseg_in),
        .bcd_out    (bcd_out),
        .value_out  (value_out),
        .frame_valid(frame_valid),
        .changed    (changed),
        .seg_err    (seg_err),
        .dp_err     (dp_err),
        .en_err     (en_err),
        .stale      (stale),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int frame_cnt = 0;
    int en_err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected frame per frame_valid strobe
    always @(negedge clk) begin
        if (rst && en_err) en_err_cnt++;
        if (rst && frame_valid) begin
            frame_cnt++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_frame: got bcd=%0h value=%0d changed=%0b, none expected",
                         bcd_out, value_out, changed);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({bcd_out, value_out, changed} !== e) begin
                    n_err++;
                    $display("FAIL frame: got bcd=%0h value=%0d changed=%0b expected bcd=%0h value=%0d changed=%0b",
                             bcd_out, value_out, changed, e[22:11], e[10:1], e[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] e, input logic [7:0] s, input int n);
        en_in   = e;
        sseg_in = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] o, input logic [7:0] t, input logic [7:0] h);
        drive(3'b110, o, HOLD_CYC);
        drive(3'b101, t, HOLD_CYC);
        drive(3'b011, h, HOLD_CYC);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bcd"},   32'(bcd_out),     32'h0);
        check({tag, "_value"}, 32'(value_out),   32'h0);
        check({tag, "_fv"},    32'(frame_valid), 32'h0);
        check({tag, "_chg"},   32'(changed),     32'h0);
        check({tag, "_seg"},   32'(seg_err),     32'h0);
        check({tag, "_dp"},    32'(dp_err),      32'h0);
        check({tag, "_en"},    32'(en_err),      32'h0);
        check({tag, "_stale"}, 32'(stale),       32'h0);
        check({tag, "_state"}, 32'(dbg_state),   32'h0);
    endtask

    // Watchdog: the stimulus is fixed-length, this only guards against a hang
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int f0;
        int e0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: frame 125 (ones 5, tens 2 with dp, hundreds 1)
        exp_q.push_back({12'h125, 10'd125, 1'b1});
        send_frame(8'h49, 8'h24, 8'h9F);
        check("t1_seg_err", 32'(seg_err), 32'h0);
        check("t1_dp_err",  32'(dp_err),  32'h0);

        // 2: repeat (unchanged), ones 6, then frames covering 8/4/7 and 3/0
        exp_q.push_back({12'h125, 10'd125, 1'b0});
        send_frame(8'h49, 8'h24, 8'h9F);
        exp_q.push_back({12'h126, 10'd126, 1'b1});
        send_frame(8'h41, 8'h24, 8'h9F);
        exp_q.push_back({12'h748, 10'd748, 1'b1});
        send_frame(8'h01, 8'h98, 8'h1F);
        exp_q.push_back({12'h303, 10'd303, 1'b1});
        send_frame(8'h0D, 8'h02, 8'h0D);
        check("t2_errs", 32'({seg_err, dp_err}), 32'h0);

        // 3: ones glitch of SETTLE-1 samples; tens+hundreds must not complete a frame
        f0 = frame_cnt;
        drive(3'b110, 8'h49, SETTLE - 1);
        drive(3'b111, 8'hFF, 6);
        drive(3'b101, 8'h24, HOLD_CYC);
        drive(3'b011, 8'h9F, HOLD_CYC);
        check("t3_no_frame", 32'(frame_cnt - f0), 32'h0);
        exp_q.push_back({12'h120, 10'd120, 1'b1});
        drive(3'b110, 8'h03, HOLD_CYC);
        drive(3'b111, 8'hFF, 6);
        check("t3_frame_after", 32'(frame_cnt - f0), 32'h1);

        // 4: invalid pattern, then dp lit on the ones digit
        f0 = frame_cnt;
        drive(3'b110, 8'hFF, HOLD_CYC);
        drive(3'b111, 8'hFF, 6);
        check("t4_seg_err", 32'(seg_err), 32'h1);
        check("t4_dp_clean", 32'(dp_err), 32'h0);
        drive(3'b110, 8'h48, HOLD_CYC);
        drive(3'b111, 8'hFF, 6);
        check("t4_dp_err", 32'(dp_err), 32'h1);
        check("t4_seg_sticky", 32'(seg_err), 32'h1);
        check("t4_no_frame", 32'(frame_cnt - f0), 32'h0);

        // 5: overlapping enables for one cycle, then idle past TIMEOUT
        e0 = en_err_cnt;
        drive(3'b100, 8'hFF, 1);
        drive(3'b111, 8'hFF, 6);
        check("t5_en_err_pulse", 32'(en_err_cnt - e0), 32'h1);
        check("t5_state_idle", 32'(dbg_state), 32'h0);
        drive(3'b111, 8'hFF, TIMEOUT + 10);
        check("t5_stale_set", 32'(stale), 32'h1);
        exp_q.push_back({12'h125, 10'd125, 1'b1});
        send_frame(8'h49, 8'h24, 8'h9F);
        check("t5_stale_clr", 32'(stale), 32'h0);
        check("t5_sticky", 32'({seg_err, dp_err}), 32'h3);

        // 6: reset after two latched digits discards them
        drive(3'b110, 8'h49, HOLD_CYC);
        drive(3'b101, 8'h24, HOLD_CYC);
        en_in   = 3'b111;
        sseg_in = 8'hFF;
        rst     = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("t6_rst");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        f0 = frame_cnt;
        drive(3'b011, 8'h9F, HOLD_CYC);
        drive(3'b111, 8'hFF, 6);
        check("t6_no_frame", 32'(frame_cnt - f0), 32'h0);
        // hundreds re-latched (overwrite), first frame after reset, max value
        exp_q.push_back({12'h999, 10'd999, 1'b1});
        drive(3'b011, 8'h09, HOLD_CYC);
        drive(3'b101, 8'h08, HOLD_CYC);
        drive(3'b110, 8'h09, HOLD_CYC);
        drive(3'b111, 8'hFF, 10);
        check("t6_frame_after", 32'(frame_cnt - f0), 32'h1);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
